// File: rtl/axi_stream_dw_downsizer.sv
// rtl/axi_stream_dw_downsizer.sv - wide-to-narrow AXI4 Stream width converter
// Each captured rx beat is replayed as tx slices, LSB slice first, skipping trailing null slices.
module axi_stream_dw_downsizer #(
  parameter int unsigned RxDataWidth = 64,
  parameter int unsigned TxDataWidth = 32,
  parameter type rx_chan_t = struct packed {
    logic [RxDataWidth-1:0]   data;
    logic [RxDataWidth/8-1:0] strb;
    logic [RxDataWidth/8-1:0] keep;
    logic                     last;
    logic [3:0]               id;
    logic [3:0]               dest;
    logic [0:0]               user;
  },
  parameter type tx_chan_t = struct packed {
    logic [TxDataWidth-1:0]   data;
    logic [TxDataWidth/8-1:0] strb;
    logic [TxDataWidth/8-1:0] keep;
    logic                     last;
    logic [3:0]               id;
    logic [3:0]               dest;
    logic [0:0]               user;
  },
  parameter type rx_req_t = struct packed { logic tvalid; rx_chan_t t; },
  parameter type rx_rsp_t = struct packed { logic tready; },
  parameter type tx_req_t = struct packed { logic tvalid; tx_chan_t t; },
  parameter type tx_rsp_t = struct packed { logic tready; }
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rx_req_t rx_req_i,
  output rx_rsp_t rx_rsp_o,
  output tx_req_t tx_req_o,
  input  tx_rsp_t tx_rsp_i
);

  localparam int unsigned Ratio   = RxDataWidth / TxDataWidth;
  localparam int unsigned TxBytes = TxDataWidth / 8;
  localparam int unsigned IdxW    = (Ratio > 1) ? $clog2(Ratio) : 1;

  if ((RxDataWidth % TxDataWidth) != 0 || Ratio < 1 ||
      (RxDataWidth % 8) != 0 || (TxDataWidth % 8) != 0) begin : g_bad_widths
    $error("axi_stream_dw_downsizer: RxDataWidth must be a byte-aligned multiple of TxDataWidth");
  end

  logic            valid_q;
  rx_chan_t        beat_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] end_q;
  logic [IdxW-1:0] end_d;
  logic            last_slice;
  logic            rx_hs;
  logic            tx_hs;

  // Highest slice carrying any kept byte; an all-null beat still emits slice 0.
  always_comb begin
    end_d = '0;
    for (int k = 0; k < int'(Ratio); k++) begin
      if (|rx_req_i.t.keep[k*TxBytes +: TxBytes]) begin
        end_d = IdxW'(k);
      end
    end
  end

  assign last_slice = valid_q && (idx_q == end_q);
  assign rx_hs      = rx_req_i.tvalid && rx_rsp_o.tready;
  assign tx_hs      = valid_q && tx_rsp_i.tready;

  always_comb begin
    rx_rsp_o        = '0;
    rx_rsp_o.tready = !valid_q || (last_slice && tx_rsp_i.tready);
  end

  always_comb begin
    tx_req_o        = '0;
    tx_req_o.tvalid = valid_q;
    tx_req_o.t.data = beat_q.data[idx_q*TxDataWidth +: TxDataWidth];
    tx_req_o.t.strb = beat_q.strb[idx_q*TxBytes +: TxBytes];
    tx_req_o.t.keep = beat_q.keep[idx_q*TxBytes +: TxBytes];
    tx_req_o.t.last = beat_q.last && (idx_q == end_q);
    tx_req_o.t.id   = beat_q.id;
    tx_req_o.t.dest = beat_q.dest;
    tx_req_o.t.user = beat_q.user;
  end

  // A new beat may load in the same cycle the last slice leaves, so no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
      idx_q   <= '0;
      end_q   <= '0;
    end else if (rx_hs) begin
      valid_q <= 1'b1;
      beat_q  <= rx_req_i.t;
      idx_q   <= '0;
      end_q   <= end_d;
    end else if (tx_hs) begin
      if (last_slice) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_dw_downsizer.sv
// tb/tb_axi_stream_dw_downsizer.sv - scoreboard bench for 64->32 and 64->64 downsizers
module tb_axi_stream_dw_downsizer;

  typedef struct packed {
    logic [63:0] data; logic [7:0] strb; logic [7:0] keep; logic last;
    logic [3:0] id; logic [3:0] dest; logic [1:0] user;
  } w_chan_t;
  typedef struct packed {
    logic [31:0] data; logic [3:0] strb; logic [3:0] keep; logic last;
    logic [3:0] id; logic [3:0] dest; logic [1:0] user;
  } n_chan_t;
  typedef struct packed { logic tvalid; w_chan_t t; } w_req_t;
  typedef struct packed { logic tvalid; n_chan_t t; } n_req_t;
  typedef struct packed { logic tready; } rsp_t;
  typedef struct packed { n_chan_t t; logic is_end; } exp2_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  w_req_t rx2_req, rx1_req, tx1_req;
  rsp_t   rx2_rsp, rx1_rsp, tx2_rsp, tx1_rsp;
  n_req_t tx2_req;

  axi_stream_dw_downsizer #(
    .RxDataWidth(64), .TxDataWidth(32),
    .rx_chan_t(w_chan_t), .tx_chan_t(n_chan_t),
    .rx_req_t(w_req_t), .rx_rsp_t(rsp_t), .tx_req_t(n_req_t), .tx_rsp_t(rsp_t)
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_req_i(rx2_req), .rx_rsp_o(rx2_rsp), .tx_req_o(tx2_req), .tx_rsp_i(tx2_rsp)
  );

  axi_stream_dw_downsizer #(
    .RxDataWidth(64), .TxDataWidth(64),
    .rx_chan_t(w_chan_t), .tx_chan_t(w_chan_t),
    .rx_req_t(w_req_t), .rx_rsp_t(rsp_t), .tx_req_t(w_req_t), .tx_rsp_t(rsp_t)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_req_i(rx1_req), .rx_rsp_o(rx1_rsp), .tx_req_o(tx1_req), .tx_rsp_i(tx1_rsp)
  );

  int      n_cmp = 0;
  int      n_err = 0;
  int      cyc   = 0;
  w_chan_t pend2[$], pend1[$], exp1[$];
  exp2_t   exp2[$];
  logic    rdy_pat2[$];
  logic    tx2_rdy_def = 1'b1;
  logic    rx1_v = 1'b0;
  int      rx2_cyc[$], tx2_cyc[$];
  n_chan_t tx2_log[$];
  n_chan_t prev2_t;
  logic    prev2_stall = 1'b0;
  int      occ1 = 0;
  bit      rnd1 = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_model2(input w_chan_t b);
    int e = 0;
    exp2_t x;
    for (int k = 0; k < 2; k++) if (|b.keep[k*4 +: 4]) e = k;
    for (int k = 0; k <= e; k++) begin
      x.t.data = b.data[k*32 +: 32];
      x.t.strb = b.strb[k*4 +: 4];
      x.t.keep = b.keep[k*4 +: 4];
      x.t.last = b.last && (k == e);
      x.t.id   = b.id;
      x.t.dest = b.dest;
      x.t.user = b.user;
      x.is_end = (k == e);
      exp2.push_back(x);
    end
  endtask

  task automatic drive();
    rx2_req.tvalid = (pend2.size() > 0);
    if (pend2.size() > 0) rx2_req.t = pend2[0];
    else rx2_req.t = {$urandom(), $urandom(), $urandom(), 27'($urandom())};
    if (tx2_req.tvalid && rdy_pat2.size() > 0) tx2_rsp.tready = rdy_pat2.pop_front();
    else tx2_rsp.tready = tx2_rdy_def;
    if (!rx1_v && pend1.size() > 0 && (!rnd1 || $urandom_range(0, 1) == 1)) rx1_v = 1'b1;
    rx1_req.tvalid = rx1_v;
    if (rx1_v) rx1_req.t = pend1[0];
    else rx1_req.t = {$urandom(), $urandom(), $urandom(), 27'($urandom())};
    tx1_rsp.tready = rnd1 ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Sample between edges, then advance to just past the next rising edge.
  task automatic tick();
    exp2_t e;
    @(negedge clk);
    if (rst_n) begin
      if (tx2_req.tvalid) begin
        if (exp2.size() == 0) begin
          chk("t2_spurious_slice", 1, 0);
        end else begin
          e = exp2[0];
          chk("rx2_tready", rx2_rsp.tready, e.is_end && tx2_rsp.tready);
          if (prev2_stall) chk("t2_stable", tx2_req.t, prev2_t);
          if (tx2_rsp.tready) begin
            chk("t2_slice", tx2_req.t, e.t);
            void'(exp2.pop_front());
            tx2_cyc.push_back(cyc);
            tx2_log.push_back(tx2_req.t);
          end
        end
      end else begin
        chk("rx2_tready_idle", rx2_rsp.tready, 1);
      end
      prev2_stall = tx2_req.tvalid && !tx2_rsp.tready;
      prev2_t     = tx2_req.t;
      if (rx2_req.tvalid && rx2_rsp.tready) begin
        push_model2(rx2_req.t);
        rx2_cyc.push_back(cyc);
        void'(pend2.pop_front());
      end
      if (tx1_req.tvalid && tx1_rsp.tready) begin
        if (exp1.size() == 0) chk("t1_spurious_beat", 1, 0);
        else chk("t1_beat", tx1_req.t, exp1.pop_front());
        occ1--;
      end
      if (rx1_req.tvalid && rx1_rsp.tready) begin
        exp1.push_back(rx1_req.t);
        void'(pend1.pop_front());
        rx1_v = 1'b0;
        occ1++;
        chk("t1_occupancy_le1", (occ1 <= 1), 1);
      end
    end else begin
      prev2_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((pend2.size() > 0 || exp2.size() > 0 || tx2_req.tvalid ||
            pend1.size() > 0 || exp1.size() > 0 || tx1_req.tvalid) && n < max) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (n < max), 1);
  endtask

  function automatic w_chan_t mk(input logic [63:0] d, input logic [7:0] k,
                                 input logic l, input logic [3:0] id);
    w_chan_t b;
    b.data = d; b.strb = k; b.keep = k; b.last = l;
    b.id = id; b.dest = 4'hA; b.user = 2'b10;
    return b;
  endfunction

  initial begin
    rx2_req = '0; rx1_req = '0; tx2_rsp = '0; tx1_rsp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx2_tvalid", tx2_req.tvalid, 0);
    chk("reset_rx2_tready", rx2_rsp.tready, 1);
    chk("reset_tx1_tvalid", tx1_req.tvalid, 0);
    rst_n = 1'b1;
    drive();
    tick();

    // Basic split, latency and slice ordering
    rx2_cyc.delete(); tx2_cyc.delete(); tx2_log.delete();
    pend2.push_back(mk(64'h1111_2222_3333_4444, 8'hFF, 1'b1, 4'd3));
    drive();
    run_idle(20);
    chk("t1_slice_count", tx2_log.size(), 2);
    if (tx2_log.size() == 2) begin
      chk("t1_slice0_data", tx2_log[0].data, 32'h3333_4444);
      chk("t1_slice0_last", tx2_log[0].last, 0);
      chk("t1_slice1_data", tx2_log[1].data, 32'h1111_2222);
      chk("t1_slice1_keep", tx2_log[1].keep, 4'hF);
      chk("t1_slice1_last", tx2_log[1].last, 1);
      chk("t1_slice1_id", tx2_log[1].id, 4'd3);
      chk("t1_latency", tx2_cyc[0] - rx2_cyc[0], 1);
    end

    // Back-to-back beats: eight slices without a gap
    tx2_cyc.delete();
    for (int i = 0; i < 4; i++)
      pend2.push_back(mk({$urandom(), $urandom()}, 8'hFF, (i == 3), 4'(i)));
    drive();
    run_idle(40);
    chk("b2b_slice_count", tx2_cyc.size(), 8);
    if (tx2_cyc.size() == 8) chk("b2b_no_bubble", tx2_cyc[7] - tx2_cyc[0], 7);

    // Trailing null slices and an all-null beat
    tx2_log.delete();
    pend2.push_back(mk(64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b1, 4'd5));
    pend2.push_back(mk(64'h0123_4567_89AB_CDEF, 8'h00, 1'b1, 4'd6));
    pend2.push_back(mk(64'h5555_6666_7777_8888, 8'hF0, 1'b0, 4'd7));
    drive();
    run_idle(20);
    chk("null_slice_count", tx2_log.size(), 4);
    if (tx2_log.size() == 4) begin
      chk("null_keep0f", {tx2_log[0].keep, tx2_log[0].last}, {4'hF, 1'b1});
      chk("null_keep00", {tx2_log[1].data, tx2_log[1].keep, tx2_log[1].last},
          {32'h89AB_CDEF, 4'h0, 1'b1});
      chk("null_keepf0_s1", tx2_log[3].data, 32'h5555_6666);
    end

    // Backpressure within a beat
    tx2_log.delete();
    rdy_pat2.push_back(1'b1); rdy_pat2.push_back(1'b0);
    rdy_pat2.push_back(1'b0); rdy_pat2.push_back(1'b1);
    pend2.push_back(mk(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1, 4'd9));
    pend2.push_back(mk(64'h9999_8888_7777_6666, 8'hFF, 1'b1, 4'd1));
    drive();
    run_idle(30);
    chk("bp_slice_count", tx2_log.size(), 4);

    // Asynchronous reset in the middle of a beat
    pend2.push_back(mk(64'hFEED_FACE_0BAD_F00D, 8'hFF, 1'b1, 4'd2));
    drive();
    tick();
    tick();
    chk("rst_pre_tvalid", tx2_req.tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_tx2_tvalid", tx2_req.tvalid, 0);
    chk("rst_rx2_tready", rx2_rsp.tready, 1);
    exp2.delete();
    prev2_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle_after", tx2_req.tvalid, 0);
    tx2_log.delete();
    pend2.push_back(mk(64'h1357_9BDF_2468_ACE0, 8'hFF, 1'b1, 4'd4));
    drive();
    run_idle(20);
    chk("rst_recover_count", tx2_log.size(), 2);
    if (tx2_log.size() == 2) chk("rst_recover_s0", tx2_log[0].data, 32'h2468_ACE0);

    // Ratio 1: random beats with random backpressure on both sides
    rnd1 = 1'b1;
    for (int i = 0; i < 40; i++)
      pend1.push_back(mk({$urandom(), $urandom()}, 8'($urandom()), 1'($urandom()), 4'($urandom())));
    drive();
    run_idle(2000);
    chk("r1_all_delivered", {pend1.size() == 0, exp1.size() == 0}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_stream_dw_downsizer.md
Name: axi_stream_dw_downsizer

Overview:
- Converts a wide AXI4 Stream into a narrower one by an integer ratio. Each rx beat is emitted as consecutive tx slices, least-significant slice first.
- Sits directly upstream of axi_stream_cut. The cut breaks the combinational tx_rsp_i.tready -> rx_rsp_o.tready path that this block keeps for full throughput.
- Uses the same req/rsp struct convention:
  - req fields: tvalid, t.data, t.strb, t.keep, t.last, t.id, t.dest, t.user
  - rsp field: tready

Parameters:
- RxDataWidth, 64, rx tdata width in bits; multiple of 8.
- TxDataWidth, 32, tx tdata width in bits; multiple of 8.
- rx_chan_t, logic, rx stream channel struct (data/strb/keep of RxDataWidth).
- tx_chan_t, logic, tx stream channel struct (data/strb/keep of TxDataWidth); id/dest/user widths are identical to rx_chan_t.
- rx_req_t, logic, rx request struct.
- rx_rsp_t, logic, rx response struct.
- tx_req_t, logic, tx request struct.
- tx_rsp_t, logic, tx response struct.
- Derived: Ratio = RxDataWidth/TxDataWidth. Elaboration error unless RxDataWidth % TxDataWidth == 0 and Ratio >= 1.

Ports:
- clk_i, input, 1, clock; all state on rising edge.
- rst_ni, input, 1, asynchronous reset, active low.
- rx_req_i, input, rx_req_t, wide stream request.
- rx_rsp_o, output, rx_rsp_t, wide stream response (tready).
- tx_req_o, output, tx_req_t, narrow stream request.
- tx_rsp_i, input, tx_rsp_t, narrow stream response (tready).

Behaviour:
- State:
  - valid_q: buffer holds a beat.
  - beat_q: captured rx channel.
  - idx_q: current slice index, 0..Ratio-1.
  - end_q: index of the final slice to emit for the held beat.
- Reset: valid_q=0, idx_q=0, end_q=0, beat_q=0. tx_req_o.tvalid=0 and rx_rsp_o.tready=1 (buffer empty). Asserting reset mid-beat discards the held beat and any un-emitted slices immediately.
- end computation at capture: end = highest slice index k whose keep[k*TxDataWidth/8 +: TxDataWidth/8] is non-zero. If all keep bits are zero, end = 0. Slice 0 is therefore always emitted.
- Trailing null slices (index > end) are never emitted.
- tx outputs:
  - tvalid = valid_q
  - data = beat_q.data[idx_q*TxDataWidth +: TxDataWidth]
  - strb and keep: the matching byte slices
  - id, dest, user: copied unchanged on every slice
  - last = beat_q.last && (idx_q == end_q)
- last_slice = valid_q && (idx_q == end_q).
- rx_rsp_o.tready = !valid_q || (last_slice && tx_rsp_i.tready). This is a combinational path from tx_rsp_i.tready; there is no path from rx_req_i to tx_req_o.
- rx handshake (rx tvalid && rx tready): capture beat_q, compute end_q, set idx_q=0, set valid_q=1.
- tx handshake on a non-last slice: idx_q += 1.
- tx handshake on last_slice with no rx handshake in the same cycle: valid_q=0, idx_q=0.
- Simultaneous last-slice tx handshake and rx handshake: the new beat is loaded; valid_q stays 1 with no bubble.
- Latency: first slice valid one cycle after the rx handshake.
- Throughput: one tx slice per cycle when tx tready is held high. A beat with n emitted slices occupies n cycles.
- Stability:
  - While tx tvalid=1 and tx tready=0, all tx fields stay stable.
  - tvalid never drops without a handshake, except on reset.
  - rx tvalid/data may be presented at any time; a beat is only taken on handshake.
- Ratio==1: degenerates to a single-register stage with end_q always 0. No throughput loss thanks to the ready rule.
- No combinational dependency of tvalid on tready in either direction, per AXI4 Stream.

Test Plan:
1. Ratio=2. Send rx data=0x1111_2222_3333_4444, keep=0xFF, last=1, id=3, tx tready=1. Expected: tx beats 0x3333_4444 (keep 0xF, last 0), then 0x1111_2222 (keep 0xF, last 1), both with id=3. The first tx beat appears 1 cycle after the rx handshake.
2. Back-to-back: 4 rx beats with tvalid continuously high and tx tready=1. Expected: 8 consecutive tx slices with no idle cycle. rx tready is high exactly on the cycles of the second slice of each beat, plus the first cycle.
3. Trailing null slice: rx keep=0x0F, last=1. Expected: one tx slice with keep 0xF and last=1; the next rx beat is accepted that same cycle. rx keep=0x00, last=1 -> one slice with keep 0x0 and last=1.
4. Backpressure: tx tready toggles 1,0,0,1 during a beat. Expected: slice data/keep/last stay stable while stalled, and rx tready=0 until the last slice handshakes.
5. Reset mid-beat: capture a beat, emit slice 0, then pulse rst_ni low. Expected: tx tvalid=0 and rx tready=1 immediately. After release, the next beat starts at slice 0 and no stale slice appears.
6. Ratio=1 (64->64). Random beats with random tready at both sides. Expected: output sequence equals input sequence, with at most one beat buffered.
